// File: rtl/bip_pkg.sv
// Shared BIP definitions: loader state encoding, framing constants, header check.
package bip_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 2;
  localparam int unsigned HDR_W          = 16;

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    DAT_LO,
    DAT_HI,
    WRITE,
    DONE,
    ERROR
  } state_e;

  // A word count is legal when 1 <= n <= 2^abits.
  function automatic logic count_legal(input logic [HDR_W-1:0] n, input int unsigned abits);
    return (n != HDR_W'(0)) && (32'(n) <= (32'd1 << abits));
  endfunction

endpackage

// File: rtl/bip_program_loader_if.sv
// Byte stream in from the host plus write port out to program memory.
interface bip_program_loader_if #(
  parameter int unsigned ADDR_BITS  = 11,
  parameter int unsigned DATA_WIDTH = 16
);
  import bip_pkg::*;

  logic [BYTE_W-1:0]     rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  pm_wr;
  logic [ADDR_BITS-1:0]  pm_addr;
  logic [DATA_WIDTH-1:0] pm_data;

  // Host side: sources bytes, observes the memory write port.
  modport master (
    output rx_data, rx_valid,
    input  rx_ready, pm_wr, pm_addr, pm_data
  );

  // Loader side: sinks bytes, drives the memory write port.
  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, pm_wr, pm_addr, pm_data
  );

endinterface

// File: rtl/bip_program_loader.sv
// Streams a counted little-endian word image into program memory from address 0
// and holds the CPU in reset until the whole image has been written.
module bip_program_loader
  import bip_pkg::*;
#(
  parameter int unsigned ADDR_BITS  = 11,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  bip_program_loader_if.slave  bus,
  input  logic                 reload,
  output logic                 cpu_reset_n,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  // Remaining count needs one extra bit: N = 2^ADDR_BITS is a legal image size.
  localparam int unsigned CNT_W = ADDR_BITS + 1;

  state_e                state_q, state_d;
  logic [BYTE_W-1:0]     lo_q, lo_d;
  logic [CNT_W-1:0]      rem_q, rem_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [ADDR_BITS-1:0]  pm_addr_q, pm_addr_d;
  logic [DATA_WIDTH-1:0] pm_data_q, pm_data_d;
  logic                  pm_wr_q, pm_wr_d;
  logic                  rx_ready_q, rx_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  cpu_rst_n_q, cpu_rst_n_d;

  logic                  accept_c;
  logic [HDR_W-1:0]      hdr_count_c;

  assign accept_c    = rx_ready_q & bus.rx_valid;
  assign hdr_count_c = {bus.rx_data, lo_q};

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d   = state_q;
    lo_d      = lo_q;
    rem_d     = rem_q;
    addr_d    = addr_q;
    pm_addr_d = pm_addr_q;
    pm_data_d = pm_data_q;

    unique case (state_q)
      HDR_LO: begin
        if (accept_c) begin
          lo_d    = bus.rx_data;
          state_d = HDR_HI;
        end
      end
      HDR_HI: begin
        if (accept_c) begin
          if (count_legal(hdr_count_c, ADDR_BITS)) begin
            rem_d   = CNT_W'(hdr_count_c);
            addr_d  = '0;
            state_d = DAT_LO;
          end else begin
            state_d = ERROR;
          end
        end
      end
      DAT_LO: begin
        if (accept_c) begin
          lo_d    = bus.rx_data;
          state_d = DAT_HI;
        end
      end
      DAT_HI: begin
        if (accept_c) begin
          pm_addr_d = addr_q;
          pm_data_d = DATA_WIDTH'({bus.rx_data, lo_q});
          state_d   = WRITE;
        end
      end
      WRITE: begin
        if (rem_q == CNT_W'(1)) begin
          state_d = DONE;
        end else begin
          rem_d   = rem_q - CNT_W'(1);
          addr_d  = addr_q + ADDR_BITS'(1);
          state_d = DAT_LO;
        end
      end
      DONE, ERROR: begin
        if (reload) begin
          state_d = HDR_LO;
        end
      end
      default: state_d = HDR_LO;
    endcase

    rx_ready_d  = (state_d == HDR_LO) || (state_d == HDR_HI) ||
                  (state_d == DAT_LO) || (state_d == DAT_HI);
    busy_d      = (state_d == HDR_HI) || (state_d == DAT_LO) ||
                  (state_d == DAT_HI) || (state_d == WRITE);
    pm_wr_d     = (state_d == WRITE);
    done_d      = (state_d == DONE);
    error_d     = (state_d == ERROR);
    cpu_rst_n_d = (state_d == DONE);
  end

  // State and output registers; synchronous active-low reset clears everything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= HDR_LO;
      lo_q        <= '0;
      rem_q       <= '0;
      addr_q      <= '0;
      pm_addr_q   <= '0;
      pm_data_q   <= '0;
      pm_wr_q     <= 1'b0;
      rx_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      rem_q       <= rem_d;
      addr_q      <= addr_d;
      pm_addr_q   <= pm_addr_d;
      pm_data_q   <= pm_data_d;
      pm_wr_q     <= pm_wr_d;
      rx_ready_q  <= rx_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  assign bus.rx_ready = rx_ready_q;
  assign bus.pm_wr    = pm_wr_q;
  assign bus.pm_addr  = pm_addr_q;
  assign bus.pm_data  = pm_data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign cpu_reset_n  = cpu_rst_n_q;

endmodule

// File: tb/tb_bip_program_loader.sv
// Randomized self-checking bench for bip_program_loader against a frame-level model.
module tb_bip_program_loader;

  localparam int unsigned ADDR_BITS  = 11;
  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned CAPACITY   = 1 << ADDR_BITS;

  logic clk = 1'b0;
  logic reset;
  logic reload;
  logic cpu_reset_n, busy, done, error;

  int n_checks = 0;
  int n_fail   = 0;

  bip_program_loader_if #(.ADDR_BITS(ADDR_BITS), .DATA_WIDTH(DATA_WIDTH)) bif ();

  bip_program_loader #(.ADDR_BITS(ADDR_BITS), .DATA_WIDTH(DATA_WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bif),
    .reload      (reload),
    .cpu_reset_n (cpu_reset_n),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  // Write-port monitor: log every pm_wr and the cycles done / cpu_reset_n rise.
  logic [ADDR_BITS-1:0]  wr_addr_q [$];
  logic [DATA_WIDTH-1:0] wr_data_q [$];
  int                    wr_cyc_q  [$];
  int  cyc       = 0;
  int  done_cyc  = -1;
  int  crst_cyc  = -1;
  int  dbl_wr    = 0;
  bit  prev_wr   = 1'b0;
  bit  prev_done = 1'b0;
  bit  prev_crst = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bif.pm_wr) begin
      wr_addr_q.push_back(bif.pm_addr);
      wr_data_q.push_back(bif.pm_data);
      wr_cyc_q.push_back(cyc);
      if (prev_wr) dbl_wr = dbl_wr + 1;
    end
    if (done && !prev_done) done_cyc = cyc;
    if (cpu_reset_n && !prev_crst) crst_cyc = cyc;
    prev_wr   = bif.pm_wr;
    prev_done = done;
    prev_crst = cpu_reset_n;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one byte (optionally after random idle cycles); returns at the negedge after it is taken.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit noisy);
    int budget;
    while (gap > 0 && $urandom_range(99) < gap) begin
      bif.rx_valid = 1'b0;
      bif.rx_data  = 8'($urandom);
      reload       = noisy ? 1'($urandom_range(1)) : 1'b0;
      @(negedge clk);
    end
    reload       = 1'b0;
    bif.rx_data  = b;
    bif.rx_valid = 1'b1;
    budget = 40;
    while (!bif.rx_ready && budget > 0) begin
      @(negedge clk);
      budget = budget - 1;
    end
    if (budget == 0) check("send/ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bif.rx_valid = 1'b0;
  endtask

  task automatic do_reload(input string tag);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check({tag, "/reload_cpu_reset_n"}, 32'(cpu_reset_n), 32'd0);
    check({tag, "/reload_rx_ready"},    32'(bif.rx_ready), 32'd1);
    check({tag, "/reload_done"},        32'(done), 32'd0);
    check({tag, "/reload_error"},       32'(error), 32'd0);
    check({tag, "/reload_busy"},        32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/rx_ready"},    32'(bif.rx_ready), 32'd0);
    check({tag, "/pm_wr"},       32'(bif.pm_wr), 32'd0);
    check({tag, "/pm_addr"},     32'(bif.pm_addr), 32'd0);
    check({tag, "/pm_data"},     32'(bif.pm_data), 32'd0);
    check({tag, "/cpu_reset_n"}, 32'(cpu_reset_n), 32'd0);
    check({tag, "/busy"},        32'(busy), 32'd0);
    check({tag, "/done"},        32'(done), 32'd0);
    check({tag, "/error"},       32'(error), 32'd0);
  endtask

  // Stream a whole frame and compare against the model: a legal header N writes
  // stim_words[i] to address i for i < N then completes; anything else errors out.
  logic [15:0] stim_words [$];

  task automatic run_load(input logic [15:0] hdr, input int gap, input bit noisy,
                          input bit timing, input string tag);
    bit legal;
    int n, budget, mism, last;
    legal = (hdr >= 16'd1) && (32'(hdr) <= CAPACITY);
    n     = legal ? int'(hdr) : 0;
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    send_byte(hdr[7:0], gap, noisy);
    check({tag, "/busy_after_first_byte"}, 32'(busy), 32'd1);
    send_byte(hdr[15:8], gap, noisy);
    for (int i = 0; i < n; i++) begin
      logic [15:0] w;
      w = stim_words[i];
      send_byte(w[7:0], gap, noisy);
      send_byte(w[15:8], gap, noisy);
    end
    budget = 50;
    while (!(done || error) && budget > 0) begin
      @(negedge clk);
      budget = budget - 1;
    end
    check({tag, "/finished"}, 32'(done | error), 32'd1);
    @(negedge clk);
    check({tag, "/done"},        32'(done), 32'(legal));
    check({tag, "/error"},       32'(error), 32'(!legal));
    check({tag, "/cpu_reset_n"}, 32'(cpu_reset_n), 32'(legal));
    check({tag, "/rx_ready"},    32'(bif.rx_ready), 32'd0);
    check({tag, "/busy"},        32'(busy), 32'd0);
    check({tag, "/n_writes"},    32'(wr_addr_q.size()), 32'(n));
    mism = 0;
    for (int i = 0; i < wr_addr_q.size() && i < n; i++) begin
      if (32'(wr_addr_q[i]) != 32'(i) || wr_data_q[i] != stim_words[i]) mism = mism + 1;
    end
    check({tag, "/write_mismatches"}, 32'(mism), 32'd0);
    if (legal && wr_addr_q.size() > 0) begin
      last = wr_addr_q.size() - 1;
      check({tag, "/last_addr"}, 32'(wr_addr_q[last]), 32'(n - 1));
      check({tag, "/last_data"}, 32'(wr_data_q[last]), 32'(stim_words[n-1]));
      if (timing) begin
        for (int i = 1; i < wr_cyc_q.size(); i++)
          check({tag, "/wr_spacing"}, 32'(wr_cyc_q[i] - wr_cyc_q[i-1]), 32'd3);
        check({tag, "/done_latency"}, 32'(done_cyc - wr_cyc_q[last]), 32'd1);
        check({tag, "/crst_latency"}, 32'(crst_cyc - wr_cyc_q[last]), 32'd1);
      end
    end
    if (!legal) begin
      bif.rx_valid = 1'b1;
      bif.rx_data  = 8'($urandom);
      repeat (3) @(negedge clk);
      bif.rx_valid = 1'b0;
      check({tag, "/err_still_blocked"}, 32'(bif.rx_ready), 32'd0);
      check({tag, "/err_no_writes"},     32'(wr_addr_q.size()), 32'd0);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b0;
    reload       = 1'b0;
    bif.rx_valid = 1'b0;
    bif.rx_data  = 8'h00;

    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b1;
    @(negedge clk);
    check("por/rx_ready_up",   32'(bif.rx_ready), 32'd1);
    check("por/cpu_held",      32'(cpu_reset_n), 32'd0);
    check("por/idle_not_busy", 32'(busy), 32'd0);

    // Directed three-word image, streamed back to back.
    stim_words = '{16'h1234, 16'hABCD, 16'h0001};
    run_load(16'd3, 0, 1'b0, 1'b1, "n3");
    do_reload("n3");

    // Same image with random idle cycles and stray reload pulses mid-load.
    run_load(16'd3, 40, 1'b1, 1'b0, "n3_gaps");
    do_reload("n3_gaps");

    // Illegal headers just outside both ends of the legal range.
    stim_words.delete();
    run_load(16'h0000, 0, 1'b0, 1'b0, "hdr0");
    do_reload("hdr0");
    run_load(16'h0801, 0, 1'b0, 1'b0, "hdr801");
    do_reload("hdr801");

    // Random legal images and random oversized headers.
    for (int k = 0; k < 4; k++) begin
      int n;
      n = $urandom_range(24, 1);
      stim_words.delete();
      for (int i = 0; i < n; i++) stim_words.push_back(16'($urandom));
      run_load(16'(n), 30, 1'b1, 1'b0, "rand_ok");
      do_reload("rand_ok");
    end
    for (int k = 0; k < 2; k++) begin
      stim_words.delete();
      run_load(16'($urandom_range(65535, 2049)), 20, 1'b0, 1'b0, "rand_bad");
      do_reload("rand_bad");
    end

    // Full-capacity image: every word holds its own address.
    stim_words.delete();
    for (int i = 0; i < int'(CAPACITY); i++) stim_words.push_back(16'(i));
    run_load(16'h0800, 0, 1'b0, 1'b1, "full");
    do_reload("full");

    // Reset in the middle of an N=4 load, after two words have been written.
    wr_addr_q.delete();
    send_byte(8'h04, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h11, 0, 1'b0);
    send_byte(8'h22, 0, 1'b0);
    send_byte(8'h33, 0, 1'b0);
    send_byte(8'h44, 0, 1'b0);
    repeat (2) @(negedge clk);
    check("midrst/partial_writes", 32'(wr_addr_q.size()), 32'd2);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("midrst");
    reset = 1'b1;
    @(negedge clk);
    check("midrst/rx_ready_up", 32'(bif.rx_ready), 32'd1);
    stim_words = '{16'hBEEF};
    run_load(16'd1, 0, 1'b0, 1'b1, "beef");

    // Reload after done, then a fresh two-word image.
    do_reload("after_beef");
    stim_words = '{16'($urandom), 16'($urandom)};
    run_load(16'd2, 10, 1'b0, 1'b0, "n2");

    check("pm_wr_single_cycle", 32'(dbl_wr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
